// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM pattern generator / receiver pair.
// Holds the default pattern width, duty-count width and receiver state type.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;
  localparam int PWM_CW    = $clog2(PWM_WIDTH) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pwm_rx_state_t;

endpackage

// File: rtl/pwm_popcount.sv
// Combinational ones-count of a WIDTH-bit word.
// The result is one bit wider than log2(WIDTH) so an all-ones word is representable.
module pwm_popcount
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(value[i]);
    end
  end

endmodule

// File: rtl/pwm_rx.sv
// Serial receiver for the PWM pattern generator: rebuilds the rotating pattern,
// reports its duty and flags lock when consecutive frames match.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for the first sof; sin is ignored
//   SHIFT | receiving frames back to back, cnt = index of next bit
module pwm_rx
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sin,
  input  logic             sof,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic [CW-1:0]    duty,
  output logic             locked,
  output logic             frame_err
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  pwm_rx_state_t    state;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] prev;
  logic             have_prev;
  logic [WIDTH-1:0] next_word;
  logic [CW-1:0]    next_duty;

  // LSB arrives first, so after WIDTH right-shifts bit 0 sits at position 0.
  assign next_word = {sin, shreg[WIDTH-1:1]};

  pwm_popcount #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_popcount (
    .value (next_word),
    .count (next_duty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      prev       <= '0;
      have_prev  <= 1'b0;
      word       <= '0;
      duty       <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (sof) begin
              shreg <= {sin, {(WIDTH-1){1'b0}}};
              cnt   <= CNTW'(1);
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (sof && cnt != '0) begin
              // Misaligned frame: resync on this bit and forget lock history.
              frame_err <= 1'b1;
              shreg     <= {sin, {(WIDTH-1){1'b0}}};
              cnt       <= CNTW'(1);
              locked    <= 1'b0;
              have_prev <= 1'b0;
            end else begin
              shreg <= next_word;
              if (cnt == LAST_BIT) begin
                word       <= next_word;
                duty       <= next_duty;
                word_valid <= 1'b1;
                locked     <= have_prev && (next_word == prev);
                prev       <= next_word;
                have_prev  <= 1'b1;
                cnt        <= '0;
              end else begin
                cnt <= cnt + CNTW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_rx.sv
// Self-checking bench for pwm_rx: table-driven frames, hand-written corner
// sequences and randomized traffic, all against a queue-based frame model.
`timescale 1ns/1ps
module tb_pwm_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, sin, sof;
  logic [15:0] word;
  logic        word_valid;
  logic [4:0]  duty;
  logic        locked;
  logic        frame_err;

  pwm_rx dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sin        (sin),
    .sof        (sof),
    .word       (word),
    .word_valid (word_valid),
    .duty       (duty),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // Reference model: frame bits collected in a queue.
  bit          m_active;
  bit          m_q[$];
  logic [15:0] m_word, m_prev;
  logic [4:0]  m_duty;
  bit          m_valid, m_err, m_locked, m_have_prev;

  typedef struct {
    logic [15:0] pat;
    bit          gap;
    logic [15:0] exp_word;
    logic [4:0]  exp_duty;
    bit          exp_locked;
  } frame_vec_t;

  frame_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_q.delete();
    m_word = '0; m_prev = '0; m_duty = '0;
    m_valid = 0; m_err = 0; m_locked = 0; m_have_prev = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit f);
    logic [15:0] w;
    m_valid = 0;
    m_err   = 0;
    if (e) begin
      if (!m_active) begin
        if (f) begin
          m_active = 1;
          m_q.delete();
          m_q.push_back(s);
        end
      end else if (f && m_q.size() != 0) begin
        m_err = 1;
        m_q.delete();
        m_q.push_back(s);
        m_locked = 0;
        m_have_prev = 0;
      end else begin
        m_q.push_back(s);
        if (m_q.size() == 16) begin
          for (int i = 0; i < 16; i++) w[i] = m_q[i];
          m_word  = w;
          m_duty  = 5'($countones(w));
          m_valid = 1;
          m_locked = m_have_prev && (w == m_prev);
          m_prev = w;
          m_have_prev = 1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("word", word, m_word);
    check("duty", duty, m_duty);
    check("word_valid", word_valid, m_valid);
    check("locked", locked, m_locked);
    check("frame_err", frame_err, m_err);
  endtask

  task automatic step(input bit e, input bit s, input bit f);
    en = e; sin = s; sof = f;
    @(posedge clk);
    model_step(e, s, f);
    #1;
    check_outputs();
    if (word_valid) valid_cnt++;
    if (frame_err) err_cnt++;
  endtask

  // Sends the first n bits of pat; optional idle (en=0) cycle with noise between samples.
  task automatic send_bits(input logic [15:0] pat, input int n, input bit gap, input bit first_sof);
    for (int i = 0; i < n; i++) begin
      step(1'b1, pat[i], first_sof && (i == 0));
      if (gap && i < n - 1) step(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"}, word, 16'h0);
    check({tag, "_duty"}, duty, 5'd0);
    check({tag, "_valid"}, word_valid, 1'b0);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_err"}, frame_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;

    vecs[0] = '{16'h00FF, 1'b0, 16'h00FF, 5'd8,  1'b0};
    vecs[1] = '{16'h00FF, 1'b0, 16'h00FF, 5'd8,  1'b1};
    vecs[2] = '{16'hFFFF, 1'b0, 16'hFFFF, 5'd16, 1'b0};
    vecs[3] = '{16'h0001, 1'b0, 16'h0001, 5'd1,  1'b0};
    vecs[4] = '{16'hA5A5, 1'b1, 16'hA5A5, 5'd8,  1'b0};
    vecs[5] = '{16'hA5A5, 1'b1, 16'hA5A5, 5'd8,  1'b1};

    reset = 1'b1; en = 1'b0; sin = 1'b0; sof = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Idle with traffic but no sof.
    valid_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b0);
    check("idle_valid_cnt", valid_cnt, 0);
    check("idle_word", word, 16'h0);
    check("idle_locked", locked, 1'b0);

    // Table-driven frames.
    foreach (vecs[k]) begin
      valid_cnt = 0; err_cnt = 0;
      send_bits(vecs[k].pat, 16, vecs[k].gap, 1'b1);
      check($sformatf("vec%0d_valid", k), word_valid, 1'b1);
      check($sformatf("vec%0d_word", k), word, vecs[k].exp_word);
      check($sformatf("vec%0d_duty", k), duty, vecs[k].exp_duty);
      check($sformatf("vec%0d_locked", k), locked, vecs[k].exp_locked);
      check($sformatf("vec%0d_valid_cnt", k), valid_cnt, 1);
      check($sformatf("vec%0d_err_cnt", k), err_cnt, 0);
    end

    // Re-sof at bit 7 while locked.
    send_bits(16'h1234, 7, 1'b0, 1'b1);
    valid_cnt = 0; err_cnt = 0;
    pat = 16'h3C3C;
    step(1'b1, pat[0], 1'b1);
    check("resof_err", frame_err, 1'b1);
    check("resof_locked", locked, 1'b0);
    for (int i = 1; i < 16; i++) step(1'b1, pat[i], 1'b0);
    check("resof_valid_cnt", valid_cnt, 1);
    check("resof_err_cnt", err_cnt, 1);
    check("resof_word", word, 16'h3C3C);
    check("resof_duty", duty, 5'd8);
    check("resof_valid_last", word_valid, 1'b1);

    // sof on the last-bit sample: old frame must not complete.
    send_bits(16'h0F0F, 15, 1'b0, 1'b1);
    valid_cnt = 0; err_cnt = 0;
    send_bits(16'h3C3C, 16, 1'b0, 1'b1);
    check("lastbit_valid_cnt", valid_cnt, 1);
    check("lastbit_err_cnt", err_cnt, 1);
    check("lastbit_word", word, 16'h3C3C);
    check("lastbit_locked", locked, 1'b0);

    // Lock, then async reset at bit 9.
    send_bits(16'h3C3C, 16, 1'b0, 1'b1);
    check("prereset_locked", locked, 1'b1);
    send_bits(16'h3C3C, 9, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    valid_cnt = 0;
    send_bits(16'h00FF, 16, 1'b0, 1'b0);
    check("post_reset_nosof_valid_cnt", valid_cnt, 0);
    send_bits(16'h5A5A, 16, 1'b0, 1'b1);
    check("post_reset_f1_locked", locked, 1'b0);
    check("post_reset_f1_word", word, 16'h5A5A);
    send_bits(16'h5A5A, 16, 1'b0, 1'b1);
    check("post_reset_f2_locked", locked, 1'b1);

    // Randomized framed traffic with stray sof and en gaps.
    pat = 16'($urandom);
    for (int r = 0; r < 15; r++) begin
      if (r % 3 == 0) pat = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        step(1'b1, pat[i], (i == 0) || ($urandom_range(0, 60) == 0));
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'($urandom));
      end
    end

    // Fully random traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
